// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: size codes, FSM encoding
// and the alignment rule shared with the pipelined CPU.
package mem_pkg;

    localparam logic [1:0] SZ_NONE = 2'b00;
    localparam logic [1:0] SZ_WORD = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_BYTE = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // Size code 00 is never legal; halves need even and words quad-aligned addresses.
    function automatic logic isAligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_WORD: return (offset == 2'b00);
            SZ_HALF: return (offset[0] == 1'b0);
            SZ_BYTE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_extract.sv
// Big-endian lane extraction and sign/zero extension of a 32-bit memory word.
module load_extract
    import mem_pkg::*;
(
    input  logic [31:0] memWord_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    // Lane 0 sits in the most significant byte of the word.
    always_comb begin
        byteSel = 8'h00;
        halfSel = 16'h0000;
        data_o  = memWord_i;
        case (offset_i)
            2'd0:    byteSel = memWord_i[31:24];
            2'd1:    byteSel = memWord_i[23:16];
            2'd2:    byteSel = memWord_i[15:8];
            default: byteSel = memWord_i[7:0];
        endcase
        halfSel = offset_i[1] ? memWord_i[15:0] : memWord_i[31:16];
        case (size_i)
            SZ_BYTE: data_o = {{24{~unsigned_i & byteSel[7]}}, byteSel};
            SZ_HALF: data_o = {{16{~unsigned_i & halfSel[15]}}, halfSel};
            default: data_o = memWord_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage sequencer: request handshake, alignment check, memory access, load extraction.
// Optional MEM_RANGE_CHECK_EN makes addresses beyond the 8 KB space raise an address error.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 13,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_wena,
    output logic [1:0]        mem_wbh,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

`ifdef MEM_RANGE_CHECK_EN
    localparam logic RANGE_CHECK = 1'b1;
`else
    localparam logic RANGE_CHECK = 1'b0;
`endif

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              memWena_q, memWena_d;
    logic [1:0]        memWbh_q, memWbh_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic [31:0]       memWdata_q, memWdata_d;
    logic              respValid_q, respValid_d;
    logic [31:0]       respRdata_q, respRdata_d;
    logic              respErr_q, respErr_d;
    logic              isStore_q, isStore_d;
    logic [1:0]        size_q, size_d;
    logic              unsigned_q, unsigned_d;

    logic              upperNonZero;
    logic              reqLegal;
    logic [31:0]       loadData;

    load_extract u_extract (
        .memWord_i  (mem_rdata),
        .offset_i   (memAddr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (unsigned_q),
        .data_o     (loadData)
    );

    assign upperNonZero = |req_addr[31:ADDR_W];
    assign reqLegal     = isAligned(req_size, req_addr[1:0]) && !(RANGE_CHECK && upperNonZero);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        memWena_d   = 1'b0;
        memWbh_d    = memWbh_q;
        memAddr_d   = memAddr_q;
        memWdata_d  = memWdata_q;
        respValid_d = respValid_q;
        respRdata_d = respRdata_q;
        respErr_d   = respErr_q;
        isStore_d   = isStore_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (reqLegal) begin
                        state_d    = ST_ACCESS;
                        cnt_d      = CNT_INIT;
                        memWena_d  = req_we;
                        memWbh_d   = req_we ? req_size : SZ_WORD;
                        memAddr_d  = req_addr[ADDR_W-1:0];
                        memWdata_d = req_wdata;
                        isStore_d  = req_we;
                        size_d     = req_size;
                        unsigned_d = req_unsigned;
                    end else begin
                        // Illegal requests bypass memory entirely, leaving its signals untouched.
                        state_d     = ST_RESP;
                        respValid_d = 1'b1;
                        respErr_d   = 1'b1;
                        respRdata_d = 32'h0;
                    end
                end
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d     = ST_RESP;
                    respValid_d = 1'b1;
                    respErr_d   = 1'b0;
                    respRdata_d = isStore_q ? 32'h0 : loadData;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d     = ST_IDLE;
                    respValid_d = 1'b0;
                    respRdata_d = 32'h0;
                    respErr_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            memWena_q   <= 1'b0;
            memWbh_q    <= 2'b00;
            memAddr_q   <= '0;
            memWdata_q  <= 32'h0;
            respValid_q <= 1'b0;
            respRdata_q <= 32'h0;
            respErr_q   <= 1'b0;
            isStore_q   <= 1'b0;
            size_q      <= SZ_NONE;
            unsigned_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            memWena_q   <= memWena_d;
            memWbh_q    <= memWbh_d;
            memAddr_q   <= memAddr_d;
            memWdata_q  <= memWdata_d;
            respValid_q <= respValid_d;
            respRdata_q <= respRdata_d;
            respErr_q   <= respErr_d;
            isStore_q   <= isStore_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE) && !rst;
    assign resp_valid = respValid_q;
    assign resp_rdata = respRdata_q;
    assign resp_err   = respErr_q;
    assign mem_wena   = memWena_q;
    assign mem_wbh    = memWbh_q;
    assign mem_addr   = memAddr_q;
    assign mem_wdata  = memWdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a big-endian memory model and a response scoreboard.
module tb_mem_access_unit;
    import mem_pkg::*;

    localparam int WAIT = 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_wena;
    logic [1:0]  mem_wbh;
    logic [12:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic        rst4, req_valid4, req_ready4, req_we4;
    logic        resp_valid4, resp_err4, mem_wena4;
    logic [31:0] resp_rdata4, mem_wdata4;
    logic [1:0]  mem_wbh4;
    logic [12:0] mem_addr4;

    logic [31:0] mem [0:2047];
    int          wenaCount = 0;
    logic [1:0]  lastWbh = 2'b00;
    int          nCompared = 0;
    int          nMismatched = 0;
    exp_t        sb[$];

    mem_access_unit #(.ADDR_W(13), .WAIT_CYCLES(WAIT)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_wena(mem_wena), .mem_wbh(mem_wbh), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_access_unit #(.ADDR_W(13), .WAIT_CYCLES(4)) u_dut4 (
        .clk(clk), .rst(rst4),
        .req_valid(req_valid4), .req_ready(req_ready4), .req_we(req_we4),
        .req_size(SZ_WORD), .req_unsigned(1'b0),
        .req_addr(32'h0000_0040), .req_wdata(32'hCAFE_F00D),
        .resp_valid(resp_valid4), .resp_ready(1'b1),
        .resp_rdata(resp_rdata4), .resp_err(resp_err4),
        .mem_wena(mem_wena4), .mem_wbh(mem_wbh4), .mem_addr(mem_addr4),
        .mem_wdata(mem_wdata4), .mem_rdata(32'h0)
    );

    assign mem_rdata = mem[mem_addr[12:2]];

    // Memory model: merge the right-justified write data into the addressed lane(s).
    int          wIdx, wShift;
    logic [31:0] wMask;
    always @(posedge clk) begin
        if (mem_wena) begin
            wenaCount = wenaCount + 1;
            lastWbh   = mem_wbh;
            wIdx      = int'(mem_addr[12:2]);
            case (mem_wbh)
                SZ_HALF: begin wShift = mem_addr[1] ? 0 : 16; wMask = 32'h0000_FFFF << wShift; end
                SZ_BYTE: begin wShift = 8 * (3 - int'(mem_addr[1:0])); wMask = 32'h0000_00FF << wShift; end
                default: begin wShift = 0; wMask = 32'hFFFF_FFFF; end
            endcase
            mem[wIdx] = (mem[wIdx] & ~wMask) | ((mem_wdata << wShift) & wMask);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One transaction: drive, wait for the response, hold it for holdCycles, then hand it off.
    task automatic applyStimulus(input string tag, input logic we, input logic [1:0] size,
                                 input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic expErr, input logic [31:0] expRdata, input int holdCycles);
        int   startW;
        int   lat;
        exp_t e;
        @(negedge clk);
        checkOutput({tag, ":req_ready"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        sb.push_back('{rdata: expRdata, err: expErr});
        startW = wenaCount;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        // Illegal requests answer one cycle after accept; legal ones after WAIT ACCESS cycles.
        checkOutput({tag, ":latency"}, 32'(lat), expErr ? 32'd1 : 32'(WAIT + 1));
        if (sb.size() == 0) begin
            checkOutput({tag, ":sb_empty"}, 32'd0, 32'd1);
            e = '{rdata: 32'h0, err: 1'b0};
        end else begin
            e = sb.pop_front();
        end
        checkOutput({tag, ":rdata"}, resp_rdata, e.rdata);
        checkOutput({tag, ":err"}, {31'b0, resp_err}, {31'b0, e.err});
        for (int i = 0; i < holdCycles; i++) begin
            @(negedge clk);
            checkOutput({tag, ":hold_valid"}, {31'b0, resp_valid}, 32'd1);
            checkOutput({tag, ":hold_rdata"}, resp_rdata, e.rdata);
            checkOutput({tag, ":hold_ready"}, {31'b0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checkOutput({tag, ":valid_drop"}, {31'b0, resp_valid}, 32'd0);
        checkOutput({tag, ":ready_back"}, {31'b0, req_ready}, 32'd1);
        checkOutput({tag, ":wena_pulses"}, 32'(wenaCount - startW), (we && !expErr) ? 32'd1 : 32'd0);
        if (we && !expErr) checkOutput({tag, ":wbh"}, {30'b0, lastWbh}, {30'b0, size});
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int seen;
        for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
        mem[8] = 32'h80FF_7F01;
        rst = 1'b1; rst4 = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = SZ_NONE; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
        req_valid4 = 1'b0; req_we4 = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset:resp_valid", {31'b0, resp_valid}, 32'd0);
        checkOutput("reset:mem_wena", {31'b0, mem_wena}, 32'd0);
        checkOutput("reset:mem_addr", {19'b0, mem_addr}, 32'd0);
        checkOutput("reset:req_ready", {31'b0, req_ready}, 32'd0);
        rst = 1'b0; rst4 = 1'b0;
        #1;
        checkOutput("reset:req_ready_rel", {31'b0, req_ready}, 32'd1);

        applyStimulus("sw_10",   1'b1, SZ_WORD, 1'b0, 32'h0000_0010, 32'h1234_5678, 1'b0, 32'h0, 0);
        applyStimulus("lw_10",   1'b0, SZ_WORD, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'h1234_5678, 0);
        applyStimulus("lb_20",   1'b0, SZ_BYTE, 1'b0, 32'h0000_0020, 32'h0,         1'b0, 32'hFFFF_FF80, 0);
        applyStimulus("lbu_20",  1'b0, SZ_BYTE, 1'b1, 32'h0000_0020, 32'h0,         1'b0, 32'h0000_0080, 0);
        applyStimulus("lb_22",   1'b0, SZ_BYTE, 1'b0, 32'h0000_0022, 32'h0,         1'b0, 32'h0000_007F, 0);
        applyStimulus("lb_21",   1'b0, SZ_BYTE, 1'b0, 32'h0000_0021, 32'h0,         1'b0, 32'hFFFF_FFFF, 0);
        applyStimulus("lbu_23",  1'b0, SZ_BYTE, 1'b1, 32'h0000_0023, 32'h0,         1'b0, 32'h0000_0001, 0);
        applyStimulus("lh_20",   1'b0, SZ_HALF, 1'b0, 32'h0000_0020, 32'h0,         1'b0, 32'hFFFF_80FF, 0);
        applyStimulus("lhu_20",  1'b0, SZ_HALF, 1'b1, 32'h0000_0020, 32'h0,         1'b0, 32'h0000_80FF, 0);
        applyStimulus("lh_22",   1'b0, SZ_HALF, 1'b0, 32'h0000_0022, 32'h0,         1'b0, 32'h0000_7F01, 0);
        applyStimulus("lwu_20",  1'b0, SZ_WORD, 1'b1, 32'h0000_0020, 32'h0,         1'b0, 32'h80FF_7F01, 0);
        applyStimulus("sb_31",   1'b1, SZ_BYTE, 1'b0, 32'h0000_0031, 32'h0000_0033, 1'b0, 32'h0, 0);
        applyStimulus("sh_32",   1'b1, SZ_HALF, 1'b0, 32'h0000_0032, 32'h0000_BEEF, 1'b0, 32'h0, 0);
        applyStimulus("lw_30",   1'b0, SZ_WORD, 1'b0, 32'h0000_0030, 32'h0,         1'b0, 32'h0033_BEEF, 0);
        applyStimulus("lw_22",   1'b0, SZ_WORD, 1'b0, 32'h0000_0022, 32'h0,         1'b1, 32'h0, 0);
        applyStimulus("sh_21",   1'b1, SZ_HALF, 1'b0, 32'h0000_0021, 32'h0000_1111, 1'b1, 32'h0, 0);
        applyStimulus("sz_00",   1'b0, SZ_NONE, 1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'h0, 0);
        applyStimulus("lw_bp",   1'b0, SZ_WORD, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'h1234_5678, 5);
`ifdef MEM_RANGE_CHECK_EN
        applyStimulus("lw_2010", 1'b0, SZ_WORD, 1'b0, 32'h0000_2010, 32'h0,         1'b1, 32'h0, 0);
`else
        applyStimulus("lw_2010", 1'b0, SZ_WORD, 1'b0, 32'h0000_2010, 32'h0,         1'b0, 32'h1234_5678, 0);
`endif
        checkOutput("sb:drained", 32'(sb.size()), 32'd0);

        // Abort a store two cycles into its four-cycle ACCESS window.
        @(negedge clk);
        checkOutput("rst4:ready_pre", {31'b0, req_ready4}, 32'd1);
        req_valid4 = 1'b1; req_we4 = 1'b1;
        @(negedge clk);
        req_valid4 = 1'b0;
        @(negedge clk);
        rst4 = 1'b1;
        @(negedge clk);
        rst4 = 1'b0;
        checkOutput("rst4:mem_wena", {31'b0, mem_wena4}, 32'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (resp_valid4) seen++;
        end
        checkOutput("rst4:no_resp", 32'(seen), 32'd0);
        checkOutput("rst4:ready_post", {31'b0, req_ready4}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
